// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: default sizing, the configuration
// FSM state type and a helper for the channel-index width.
package tick_sched_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int DIV_W_DEF  = 26;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } cfg_state_e;

    // A single-channel build still needs a one-bit index port.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_scheduler_channel.sv
// One divide-by-N tick channel: counts prescaler ticks, emits a one-cycle
// strobe at terminal count and toggles a square wave on every strobe.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             pre_tick,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    input  logic             load_en,
    output logic             tick,
    output logic             clk_out
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic             running;
    logic             terminal;

    always_comb begin
        div_d    = div_q;
        en_d     = en_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        running  = en_q && (div_q != '0);
        terminal = running && pre_tick && (cnt_q == div_q - DIV_W'(1));
        // A reload beats a coincident terminal count: counter restarts, no strobe.
        if (load) begin
            div_d = load_div;
            en_d  = load_en;
            cnt_d = '0;
        end else if (running && pre_tick) begin
            cnt_d  = terminal ? '0 : cnt_q + DIV_W'(1);
            tick_d = terminal;
        end
        clk_d = clk_q ^ tick_d;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            en_q   <= 1'b0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            en_q   <= en_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_q;

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: shared prescaler, two-state config port and
// NUM_CH independent tick channels. Define TICK_IRQ_EN for sticky pending/irq.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int DIV_W    = DIV_W_DEF,
    parameter int PRESCALE = 100
) (
    input  logic                      clk_100MHz,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]          cfg_div,
    input  logic                      cfg_en,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         clk_out,
    input  logic [NUM_CH-1:0]         irq_clr,
    output logic                      irq
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam int PS_W = $clog2(PRESCALE);

    logic [PS_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic             pre_tick;
    cfg_state_e       state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             en_q, en_d;
    logic             apply;
    logic [NUM_CH-1:0] load;

    assign pre_tick  = (pre_cnt_q == PS_W'(PRESCALE - 1));
    assign pre_cnt_d = pre_tick ? '0 : pre_cnt_q + PS_W'(1);

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        div_d     = div_q;
        en_d      = en_q;
        cfg_ready = 1'b0;
        apply     = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    ch_d    = cfg_ch;
                    div_d   = cfg_div;
                    en_d    = cfg_en;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                apply   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            pre_cnt_q <= '0;
            state_q   <= IDLE;
            ch_q      <= '0;
            div_q     <= '0;
            en_q      <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            state_q   <= state_d;
            ch_q      <= ch_d;
            div_q     <= div_d;
            en_q      <= en_d;
        end
    end

    // Out-of-range indices match no channel, so such writes are dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign load[gi] = apply && (ch_q == CH_W'(gi));
            tick_channel #(.DIV_W(DIV_W)) u_ch (
                .clk_100MHz (clk_100MHz),
                .reset      (reset),
                .pre_tick   (pre_tick),
                .load       (load[gi]),
                .load_div   (div_q),
                .load_en    (en_q),
                .tick       (tick[gi]),
                .clk_out    (clk_out[gi])
            );
        end
    endgenerate

`ifdef TICK_IRQ_EN
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic              irq_q;

    // A strobe arriving with its clear leaves the flag set.
    assign pending_d = (pending_q & ~irq_clr) | tick;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= |pending_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = ^irq_clr;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed scoreboard bench for tick_scheduler (PRESCALE=4, NUM_CH=4).
module tb_tick_scheduler;

    localparam int NCH = 4;
    localparam int DW  = 26;
    localparam int PS  = 4;

    logic           clk_100MHz = 1'b0;
    logic           reset;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [DW-1:0]  cfg_div;
    logic           cfg_en;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] irq_clr;
    logic           irq;

    tick_scheduler #(.NUM_CH(NCH), .DIV_W(DW), .PRESCALE(PS)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_en     (cfg_en),
        .tick       (tick),
        .clk_out    (clk_out),
        .irq_clr    (irq_clr),
        .irq        (irq)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct packed {
        logic [3:0] tck;
        logic [3:0] clk;
        logic       rdy;
        logic       irq;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference state: per-channel config plus the edge at which it was loaded.
    int         en_m[4];
    int         div_m[4];
    int         l_m[4];
    logic [3:0] clk_m;
    logic [3:0] tick_m;
    logic [3:0] pirq_m;
    logic       rdy_m;
    bit         pend;
    int         pend_ch, pend_div, pend_en, pend_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Prescaler strobes are sampled at edges that are multiples of PS after reset.
    function automatic bit exp_tick(input int ch, input int e);
        int p, n;
        if (en_m[ch] == 0 || div_m[ch] == 0) return 1'b0;
        if ((e % PS) != 0 || e <= l_m[ch]) return 1'b0;
        p = l_m[ch] - (l_m[ch] % PS) + PS;
        n = (e - p) / PS;
        return ((n + 1) % div_m[ch]) == 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            en_m[i]  = 0;
            div_m[i] = 0;
            l_m[i]   = 0;
        end
        clk_m  = '0;
        tick_m = '0;
        pirq_m = '0;
        rdy_m  = 1'b1;
        pend   = 1'b0;
        cyc    = 0;
        sb_q.delete();
    endtask

    task automatic step();
        exp_t       x;
        int         e;
        logic [3:0] t;
        bit         acc;
        e   = cyc + 1;
        acc = cfg_valid && rdy_m;
        for (int i = 0; i < 4; i++) begin
            if (pend && pend_edge == e && pend_ch == i) t[i] = 1'b0;
            else t[i] = exp_tick(i, e);
        end
        if (pend && pend_edge == e) begin
            en_m[pend_ch]  = pend_en;
            div_m[pend_ch] = pend_div;
            l_m[pend_ch]   = e;
            pend = 1'b0;
        end
        if (acc) begin
            pend      = 1'b1;
            pend_ch   = int'(cfg_ch);
            pend_div  = int'(cfg_div);
            pend_en   = int'(cfg_en);
            pend_edge = e + 1;
        end
`ifdef TICK_IRQ_EN
        pirq_m = (pirq_m & ~irq_clr) | tick_m;
        x.irq  = |pirq_m;
`else
        x.irq  = 1'b0;
`endif
        clk_m  = clk_m ^ t;
        tick_m = t;
        rdy_m  = !acc;
        x.tck  = t;
        x.clk  = clk_m;
        x.rdy  = rdy_m;
        sb_q.push_back(x);
        @(posedge clk_100MHz);
        #1;
        cyc = e;
        x = sb_q.pop_front();
        chk("tick",      32'(tick),      32'(x.tck));
        chk("clk_out",   32'(clk_out),   32'(x.clk));
        chk("cfg_ready", 32'(cfg_ready), 32'(x.rdy));
        chk("irq",       32'(irq),       32'(x.irq));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic write(input int ch, input int dv, input int en);
        $display("cycle %0d: write ch=%0d div=%0d en=%0d", cyc, ch, dv, en);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = DW'(dv);
        cfg_en    = 1'(en);
        chk("cfg_ready_before_write", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int bd[4];
        int et;
        int i;
        bd = '{2, 1, 3, 2};

        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_en    = 1'b0;
        irq_clr   = '0;
        model_reset();
        repeat (3) @(posedge clk_100MHz);
        #1;
        chk("reset_tick",    32'(tick),      32'd0);
        chk("reset_clk_out", 32'(clk_out),   32'd0);
        chk("reset_irq",     32'(irq),       32'd0);
        reset = 1'b0;
        chk("ready_after_reset", 32'(cfg_ready), 32'd1);
        run(6);

        // ch0 div=3: strobe every 12 cycles, square wave period 24
        write(0, 3, 1);
        run(60);

        // ch1 stopped with div=0, then div=1 strobes every prescaler period
        write(1, 0, 1);
        run(20);
        write(1, 1, 1);
        run(20);

        // ch2 rewrite landing its APPLY on the terminal prescaler strobe
        write(2, 2, 1);
        run(10);
        et = 0;
        for (int f = cyc + 2; f < cyc + 100; f++) begin
            if (exp_tick(2, f)) begin
                et = f;
                break;
            end
        end
        chk("apply_target_found", 32'(et != 0), 32'd1);
        while (et != 0 && cyc < et - 2) step();
        write(2, 2, 1);
        step();
        chk("no_tick_on_apply", 32'(tick[2]), 32'd0);
        run(20);

        // back-to-back writes with cfg_valid held high
        cfg_valid = 1'b1;
        cfg_en    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cfg_ch  = 2'(k);
            cfg_div = DW'(bd[k]);
            $display("cycle %0d: burst write ch=%0d div=%0d en=1", cyc, k, bd[k]);
            chk("burst_ready_hi", 32'(cfg_ready), 32'd1);
            step();
            chk("burst_ready_lo", 32'(cfg_ready), 32'd0);
            step();
        end
        cfg_valid = 1'b0;
        run(40);

        // reset while a write to the running ch3 sits in APPLY
        write(3, 5, 1);
        reset = 1'b1;
        #1;
        $display("cycle %0d: reset asserted mid-apply", cyc);
        chk("midreset_tick",    32'(tick),      32'd0);
        chk("midreset_clk_out", 32'(clk_out),   32'd0);
        chk("midreset_irq",     32'(irq),       32'd0);
        chk("midreset_ready",   32'(cfg_ready), 32'd1);
        repeat (3) @(posedge clk_100MHz);
        #1;
        reset = 1'b0;
        model_reset();
        chk("ready_after_midreset", 32'(cfg_ready), 32'd1);
        run(30);

        // pending flag: clear coinciding with a strobe, then clear alone
        write(0, 2, 1);
        run(12);
        i = 0;
        while (tick_m[0] != 1'b1 && i < 40) begin
            step();
            i++;
        end
        chk("irq_tick_found", 32'(tick[0]), 32'd1);
        irq_clr = 4'b0001;
        $display("cycle %0d: irq_clr[0] with tick[0]", cyc);
        step();
`ifdef TICK_IRQ_EN
        chk("irq_set_wins", 32'(irq), 32'd1);
`else
        chk("irq_disabled_zero", 32'(irq), 32'd0);
`endif
        $display("cycle %0d: irq_clr[0] alone", cyc);
        step();
        chk("irq_cleared", 32'(irq), 32'd0);
        irq_clr = '0;
        run(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent tick channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 26, width of each channel's divide value.
REQ-003 SHALL have parameter PRESCALE, default 100, shared prescaler period in clk_100MHz cycles (>=2).
REQ-004 SHALL have port clk_100MHz  in  1  system clock.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg_valid  in  1  configuration write request.
REQ-007 SHALL have port cfg_ready  out  1  scheduler can accept a configuration write.
REQ-008 SHALL have port cfg_ch  in  $clog2(NUM_CH)  target channel index.
REQ-009 SHALL have port cfg_div  in  DIV_W  divide value, counted in prescaler ticks.
REQ-010 SHALL have port cfg_en  in  1  channel enable to load.
REQ-011 SHALL have port tick  out  NUM_CH  one-cycle strobe per channel at its terminal count.
REQ-012 SHALL have port clk_out  out  NUM_CH  square wave per channel, toggling on each tick.
REQ-013 SHALL have ports irq_clr  in  NUM_CH  pending-flag clear pulses, and irq  out  1  interrupt.

Function
REQ-014 SHALL run a free prescaler counting 0..PRESCALE-1 and wrapping to 0; pre_tick is high for the one cycle the count equals PRESCALE-1.
REQ-015 SHALL implement config FSM states IDLE and APPLY; cfg_ready = 1 only in IDLE.
REQ-016 SHALL accept a write when cfg_valid && cfg_ready, latch cfg_ch/cfg_div/cfg_en, and go IDLE->APPLY.
REQ-017 SHALL, in APPLY, load the channel's div and enable registers, clear its counter, then return to IDLE; maximum write rate is one per 2 cycles.
REQ-018 SHALL ignore a write whose cfg_ch >= NUM_CH; the handshake still completes.
REQ-019 SHALL, for an enabled channel with div>=1, advance its counter on each pre_tick; when counter == div-1 on a pre_tick, wrap the counter to 0.
REQ-020 SHALL assert tick[ch] for exactly one cycle, registered, in the cycle after the terminal pre_tick; clk_out[ch] toggles in that same cycle.
REQ-021 SHALL treat div==0 or enable==0 as stopped: counter held at 0, no tick, clk_out holds its level.
REQ-022 SHALL, when div==1, tick once per pre_tick (period PRESCALE cycles).
REQ-023 SHALL give the APPLY load priority if it coincides with that channel's terminal pre_tick: counter cleared, tick suppressed.
REQ-024 SHALL let channels run fully independently; a write to one channel leaves all others undisturbed.

Reset
REQ-025 SHALL, on reset asserted at any time: FSM=IDLE, prescaler=0, all counters/div/enable=0, tick=0, clk_out=0, pending=0, irq=0; cfg_ready=1 from the first cycle after deassertion.
REQ-026 SHALL drop a write accepted before a mid-operation reset; it is never applied.

Configuration
REQ-027 SHALL, when macro TICK_IRQ_EN is defined, keep a sticky pending[ch] set by tick[ch] and cleared by irq_clr[ch]; set wins over a simultaneous clear; irq = OR of pending, registered.
REQ-028 SHALL, without TICK_IRQ_EN, keep the irq_clr/irq ports, ignore irq_clr, and drive irq constant 0.

Structure
REQ-029 SHALL place NUM_CH/DIV_W defaults and the FSM state enum (IDLE, APPLY) in shared package tick_sched_pkg.
REQ-030 SHALL implement the per-channel counter, tick and clk_out logic in sub-module tick_channel, instantiated NUM_CH times.

Verification (PRESCALE=4, NUM_CH=4)
REQ-031 SHALL check: write ch0 div=3 en=1 -> tick[0] every 12 cycles, clk_out[0] period 24, other ticks 0.
REQ-032 SHALL check: cfg_valid held high for 4 writes -> cfg_ready pattern 1,0,1,0; each write applied exactly once.
REQ-033 SHALL check: write ch1 div=0 en=1, then div=1 -> no ticks, then a tick every 4 cycles.
REQ-034 SHALL check: rewrite ch2 with APPLY landing on its terminal pre_tick -> no tick that cycle, next tick div*4 cycles later.
REQ-035 SHALL check: reset asserted mid-APPLY with ch3 running -> all outputs 0, ch3 stopped, cfg_ready=1 after release.
REQ-036 SHALL check, with TICK_IRQ_EN: tick[0] and irq_clr[0] in the same cycle -> pending[0]=1, irq=1; irq_clr[0] alone -> irq=0.
